// File: rtl/cmp_arb_pkg.sv
// cmp_arb_pkg: shared FSM state type and match-counter limit for compare_arbiter
package cmp_arb_pkg;
  typedef enum logic [1:0] {IDLE, CMP, RESP} cmp_arb_state_t;
  localparam logic [7:0] MATCH_CNT_MAX = 8'd255;
endpackage

// File: rtl/compare_arbiter_comparator.sv
// Comparator: N-bit equality comparator shared by all requesters
module Comparator #(
  parameter int N = 3
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  output logic         eqo
);
  assign eqo = x_i == y_i;
endmodule

// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin sharing of one equality comparator among R requesters
module compare_arbiter
  import cmp_arb_pkg::*;
#(
  parameter  int N   = 3,
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_x,
  input  logic [R*N-1:0] req_y,
  output logic [R-1:0]   req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_eq,
  output logic [7:0]     match_cnt,
  output logic           busy
);
  cmp_arb_state_t state_q, state_d;
  logic [N-1:0]   op_x_q, op_y_q;
  logic [IDW-1:0] id_q, rsp_id_q, win;
  logic [7:0]     match_cnt_q;
  logic           rsp_eq_q, eqo, accept;
  // id_q doubles as last_grant: it holds the most recently accepted requester
  function automatic logic [IDW-1:0] rr_pick(input logic [R-1:0] v, input logic [IDW-1:0] last);
    logic [IDW-1:0] w;
    w = last;
    for (int k = R; k >= 1; k--)
      if (v[(int'(last) + k) % R]) w = IDW'((int'(last) + k) % R);
    return w;
  endfunction
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    win       = rr_pick(req_valid, id_q);
    accept    = state_q == IDLE && |req_valid;
    if (accept) begin
      req_ready[win] = 1'b1;
      state_d        = CMP;
    end else if (state_q == CMP) state_d = RESP;
    else if (state_q == RESP && rsp_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_x_q      <= '0;
      op_y_q      <= '0;
      id_q        <= IDW'(R - 1);
      rsp_id_q    <= '0;
      rsp_eq_q    <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      if (accept) begin
        op_x_q <= req_x[int'(win)*N +: N];
        op_y_q <= req_y[int'(win)*N +: N];
        id_q   <= win;
      end
      if (state_q == CMP) begin
        rsp_eq_q <= eqo;
        rsp_id_q <= id_q;
      end
      if (state_q == RESP && rsp_ready && rsp_eq_q && match_cnt_q != MATCH_CNT_MAX)
        match_cnt_q <= match_cnt_q + 8'd1;
    end
  Comparator #(.N(N)) u_cmp (.x_i(op_x_q), .y_i(op_y_q), .eqo(eqo));
  assign rsp_valid = state_q == RESP;
  assign rsp_id    = rsp_id_q;
  assign rsp_eq    = rsp_eq_q;
  assign match_cnt = match_cnt_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: directed self-checking bench for compare_arbiter
module tb_compare_arbiter;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_x = '0, req_y = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready = 0, rsp_eq, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  match_cnt;
  int pass_cnt = 0, tot_cnt = 0;

  compare_arbiter #(.N(3), .R(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_eq(rsp_eq), .match_cnt(match_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 0;
    #1;
    tot_cnt++; if ({req_ready, rsp_valid, rsp_id, rsp_eq, busy} !== 9'b0) $display("FAIL reset_outputs got %b exp 0", {req_ready, rsp_valid, rsp_id, rsp_eq, busy}); else pass_cnt++;
    tot_cnt++; if (match_cnt !== 8'd0) $display("FAIL reset_match_cnt got %0d exp 0", match_cnt); else pass_cnt++;
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0001; req_x[2:0] = 3'b101; req_y[2:0] = 3'b101;
    #1;
    tot_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", req_ready); else pass_cnt++;
    @(negedge clk) req_valid = '0;
    #1;
    tot_cnt++; if ({req_ready, rsp_valid, busy} !== 6'b000001) $display("FAIL single_cmp got %b exp 000001", {req_ready, rsp_valid, busy}); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if ({rsp_valid, rsp_id, rsp_eq} !== 4'b1001) $display("FAIL single_rsp got %b exp 1001", {rsp_valid, rsp_id, rsp_eq}); else pass_cnt++;
    rsp_ready = 1;
    @(negedge clk) rsp_ready = 0;
    tot_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_done got %b exp 00", {rsp_valid, busy}); else pass_cnt++;
    tot_cnt++; if (match_cnt !== 8'd1) $display("FAIL single_match_cnt got %0d exp 1", match_cnt); else pass_cnt++;
  endtask

  task automatic test_fairness();
    test_reset();
    req_x = {3'd3, 3'd2, 3'd1, 3'd5}; req_y = req_x;
    req_valid = 4'b1111; rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      tot_cnt++; if (req_ready !== 4'(1 << (i % 4))) $display("FAIL fair_grant%0d got %b exp %b", i, req_ready, 4'(1 << (i % 4))); else pass_cnt++;
      @(negedge clk);
      #1;
      tot_cnt++; if (req_ready !== 4'b0) $display("FAIL fair_cmp_ready%0d got %b exp 0000", i, req_ready); else pass_cnt++;
      @(negedge clk);
      tot_cnt++; if ({rsp_valid, rsp_id, rsp_eq} !== {1'b1, 2'(i % 4), 1'b1}) $display("FAIL fair_rsp%0d got %b exp %b", i, {rsp_valid, rsp_id, rsp_eq}, {1'b1, 2'(i % 4), 1'b1}); else pass_cnt++;
      if (i == 7) req_valid = '0;
      @(negedge clk);
    end
    rsp_ready = 0;
    tot_cnt++; if (match_cnt !== 8'd8) $display("FAIL fair_match_cnt got %0d exp 8", match_cnt); else pass_cnt++;
  endtask

  task automatic test_stall();
    req_valid = 4'b0100; req_x[8:6] = 3'b110; req_y[8:6] = 3'b111;
    #1;
    tot_cnt++; if (req_ready !== 4'b0100) $display("FAIL stall_grant got %b exp 0100", req_ready); else pass_cnt++;
    @(negedge clk) req_valid = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      tot_cnt++; if ({req_ready, rsp_valid, rsp_id, rsp_eq} !== 8'b0000_1100) $display("FAIL stall_hold%0d got %b exp 00001100", i, {req_ready, rsp_valid, rsp_id, rsp_eq}); else pass_cnt++;
      @(negedge clk);
    end
    req_valid = '0; rsp_ready = 1;
    @(negedge clk) rsp_ready = 0;
    tot_cnt++; if ({rsp_valid, match_cnt} !== {1'b0, 8'd8}) $display("FAIL stall_done got %b exp 0_00001000", {rsp_valid, match_cnt}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1000;
    #1;
    tot_cnt++; if (req_ready !== 4'b1000) $display("FAIL rmid_grant got %b exp 1000", req_ready); else pass_cnt++;
    @(negedge clk) req_valid = 4'b1111;
    tot_cnt++; if (busy !== 1'b1) $display("FAIL rmid_busy got %b exp 1", busy); else pass_cnt++;
    #2 rst_n = 0;
    #1;
    tot_cnt++; if ({busy, rsp_valid, rsp_id, rsp_eq, match_cnt} !== 13'b0) $display("FAIL rmid_cleared got %b exp 0", {busy, rsp_valid, rsp_id, rsp_eq, match_cnt}); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rmid_no_rsp got %b exp 0", rsp_valid); else pass_cnt++;
    rst_n = 1;
    #1;
    tot_cnt++; if (req_ready !== 4'b0001) $display("FAIL rmid_first_grant got %b exp 0001", req_ready); else pass_cnt++;
    @(negedge clk) req_valid = '0;
    @(negedge clk);
    tot_cnt++; if ({rsp_valid, rsp_id, rsp_eq} !== 4'b1001) $display("FAIL rmid_rsp got %b exp 1001", {rsp_valid, rsp_id, rsp_eq}); else pass_cnt++;
    rsp_ready = 1;
    @(negedge clk) rsp_ready = 0;
  endtask

  task automatic test_operand_change();
    req_valid = 4'b0010; req_x[5:3] = 3'b011; req_y[5:3] = 3'b011;
    @(negedge clk) req_valid = '0; req_x[5:3] = 3'b000;
    @(negedge clk);
    tot_cnt++; if ({rsp_valid, rsp_id, rsp_eq} !== 4'b1011) $display("FAIL opchg_eq got %b exp 1011", {rsp_valid, rsp_id, rsp_eq}); else pass_cnt++;
    rsp_ready = 1;
    @(negedge clk) rsp_ready = 0;
    req_valid = 4'b0010; req_x[5:3] = 3'b011; req_y[5:3] = 3'b010;
    #1;
    tot_cnt++; if (req_ready !== 4'b0010) $display("FAIL opchg_grant got %b exp 0010", req_ready); else pass_cnt++;
    @(negedge clk) req_valid = '0; req_x[5:3] = 3'b010;
    @(negedge clk);
    tot_cnt++; if ({rsp_valid, rsp_id, rsp_eq} !== 4'b1010) $display("FAIL opchg_ne got %b exp 1010", {rsp_valid, rsp_id, rsp_eq}); else pass_cnt++;
    rsp_ready = 1;
    @(negedge clk) rsp_ready = 0;
    tot_cnt++; if (match_cnt !== 8'd2) $display("FAIL opchg_match_cnt got %0d exp 2", match_cnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    req_x = req_y; req_valid = 4'b0001; rsp_ready = 1;
    repeat (252 * 3) @(negedge clk);
    tot_cnt++; if (match_cnt !== 8'd254) $display("FAIL sat_254 got %0d exp 254", match_cnt); else pass_cnt++;
    repeat (3) @(negedge clk);
    tot_cnt++; if (match_cnt !== 8'd255) $display("FAIL sat_255 got %0d exp 255", match_cnt); else pass_cnt++;
    repeat (7 * 3) @(negedge clk);
    tot_cnt++; if (match_cnt !== 8'd255) $display("FAIL sat_hold got %0d exp 255", match_cnt); else pass_cnt++;
    req_valid = '0; rsp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_reset_mid();
    test_operand_change();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
